// File: rtl/imm_extend_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_pkg
//   Shared encodings for the immediate-extension pipeline:
//     - extension mode codes driven on the 'mode' input
//     - skid-buffer occupancy state codes used by imm_extend_pipe
//   No ports; imported by ext_core and imm_extend_pipe.
// -----------------------------------------------------------------------------
package imm_extend_pipe_pkg;

   typedef logic [1:0] mode_t;
   typedef logic [1:0] buf_state_t;

   // Extension modes
   localparam mode_t MODE_SIGN   = 2'd0;  // sign-extend
   localparam mode_t MODE_ZERO   = 2'd1;  // zero-extend
   localparam mode_t MODE_UPPER  = 2'd2;  // immediate in the top bits
   localparam mode_t MODE_BRANCH = 2'd3;  // sign-extend then scale by 4

   // Skid-buffer occupancy
   localparam buf_state_t ST_EMPTY = 2'd0;
   localparam buf_state_t ST_ONE   = 2'd1;
   localparam buf_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_extend_pipe_ext_core.sv
// -----------------------------------------------------------------------------
// ext_core
//   Purely combinational immediate extender.
//   Ports:
//     i_imm  [IN_W-1:0]   raw immediate field
//     i_mode [1:0]        extension mode (see imm_extend_pipe_pkg)
//     o_ext  [OUT_W-1:0]  extended result
// -----------------------------------------------------------------------------
module ext_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_imm,
   input  logic [1:0]       i_mode,
   output logic [OUT_W-1:0] o_ext
);

   localparam int PAD_W = OUT_W - IN_W;

   logic             w_msb;
   logic [OUT_W-1:0] w_sign;
   logic [OUT_W-1:0] w_zero;
   logic [OUT_W-1:0] w_upper;
   logic [OUT_W-1:0] w_branch;

   assign w_msb   = i_imm[IN_W-1];
   assign w_sign  = {{PAD_W{w_msb}}, i_imm};
   assign w_zero  = {{PAD_W{1'b0}}, i_imm};
   assign w_upper = {i_imm, {PAD_W{1'b0}}};
   // Left shift by 2: the two top bits of the sign-extended value fall off.
   assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

   always_comb begin
      o_ext = w_sign;
      case (i_mode)
         MODE_SIGN:   o_ext = w_sign;
         MODE_ZERO:   o_ext = w_zero;
         MODE_UPPER:  o_ext = w_upper;
         MODE_BRANCH: o_ext = w_branch;
         default:     o_ext = w_sign;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Immediate extender followed by a 2-entry skid buffer with valid/ready
//   handshakes on both sides. The extension is done at the input, so the
//   buffer stores finished results only.
//   Ports:
//     clk        clock, all state on rising edge
//     rst        asynchronous active-high reset
//     in_valid   upstream presents imm/mode
//     in_ready   buffer can accept (registered, never depends on out_ready)
//     imm        raw immediate [IN_W-1:0]
//     mode       extension mode [1:0]
//     out_valid  ext_imm holds a result
//     out_ready  downstream takes the result
//     ext_imm    oldest buffered result [OUT_W-1:0]
// -----------------------------------------------------------------------------
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] ext_imm
);

   buf_state_t       r_state;
   logic [OUT_W-1:0] r_head;      // oldest entry, drives ext_imm
   logic [OUT_W-1:0] r_tail;      // second entry, only meaningful in FULL
   logic             r_in_ready;

   buf_state_t       w_state_nxt;
   logic [OUT_W-1:0] w_head_nxt;
   logic [OUT_W-1:0] w_tail_nxt;
   logic [OUT_W-1:0] w_ext;
   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_ext_core (
      .i_imm  (imm),
      .i_mode (mode),
      .o_ext  (w_ext)
   );

   assign w_out_valid = (r_state == ST_ONE) || (r_state == ST_FULL);
   // r_in_ready is already low in FULL, so nothing is pushed over a full buffer.
   assign w_push      = in_valid && r_in_ready;
   assign w_pop       = w_out_valid && out_ready;

   assign in_ready  = r_in_ready;
   assign out_valid = w_out_valid;
   assign ext_imm   = r_head;

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_head_nxt  = w_ext;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_push && w_pop) begin
               // Head leaves this edge, so the new result replaces it directly.
               w_head_nxt = w_ext;
            end else if (w_push) begin
               w_tail_nxt  = w_ext;
               w_state_nxt = ST_FULL;
            end else if (w_pop) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_head_nxt  = r_tail;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;  // unreachable encoding: recover
      endcase
   end

   // in_ready is registered from the next state so it has no combinational
   // path from out_ready, and stays low for the whole of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_head     <= '0;
         r_tail     <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_head     <= w_head_nxt;
         r_tail     <= w_tail_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Self-checking bench: directed vectors, backpressure, streaming,
//   mid-operation reset and a random handshake soak against a queue model.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] imm;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ext_imm;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] q[$];      // reference FIFO contents, oldest first
   bit          rdy;       // model: in_ready allowed (an edge seen since reset)
   bit          stall_prev;
   logic [31:0] ext_prev;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext_imm   (ext_imm)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference extension by plain arithmetic.
   function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
      logic [31:0] z, s;
      z = 32'(v);
      s = (v >= 16'h8000) ? z - 32'h0001_0000 : z;
      case (m)
         2'd0:    return s;
         2'd1:    return z;
         2'd2:    return z * 32'h0001_0000;
         default: return s * 32'd4;
      endcase
   endfunction

   // Called at a falling edge with inputs already driven; checks outputs,
   // advances one rising edge, updates the model, returns at the next fall.
   task automatic cyc();
      bit          push, pop;
      logic [31:0] pv;
      #1;
      chk("out_valid", 32'(out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
      if (q.size() != 0) chk("ext_imm", ext_imm, q[0]);
      chk("in_ready", 32'(in_ready), (rdy && q.size() < 2) ? 32'd1 : 32'd0);
      if (stall_prev) chk("hold", ext_imm, ext_prev);
      push       = in_valid && rdy && (q.size() < 2);
      pop        = out_ready && (q.size() != 0);
      pv         = ref_ext(imm, mode);
      stall_prev = (q.size() != 0) && !out_ready;
      ext_prev   = ext_imm;
      @(posedge clk);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(pv);
      rdy = 1'b1;
      @(negedge clk);
   endtask

   task automatic dir(input string tag, input logic [15:0] v, input logic [1:0] m,
                      input logic [31:0] exp);
      in_valid = 1'b1; imm = v; mode = m;
      cyc();
      in_valid = 1'b0;
      #1;
      chk(tag, ext_imm, exp);
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      cyc();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lows, got;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; imm = '0; mode = '0;
      rdy = 1'b0; stall_prev = 1'b0; ext_prev = '0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_ext_imm",   ext_imm,        32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // Directed extension values, one cycle after acceptance
      dir("sign_neg",  16'h8000, 2'd0, 32'hFFFF_8000);
      dir("sign_pos",  16'h7FFF, 2'd0, 32'h0000_7FFF);
      dir("zero",      16'h8000, 2'd1, 32'h0000_8000);
      dir("upper",     16'h1234, 2'd2, 32'h1234_0000);
      dir("branch_m1", 16'hFFFF, 2'd3, 32'hFFFF_FFFC);
      dir("branch_p",  16'h4001, 2'd3, 32'h0001_0004);

      // Backpressure: third push is held off until space frees
      out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
      imm = 16'h0001; cyc();
      imm = 16'h0002; cyc();
      imm = 16'h0003;
      #1 chk("bp_full_rdy", 32'(in_ready), 32'd0);
      cyc(); cyc();
      out_ready = 1'b1;
      #1 chk("bp_o1", ext_imm, 32'h1);
      cyc();
      #1 chk("bp_o2", ext_imm, 32'h2);
      cyc();
      in_valid = 1'b0;
      #1 chk("bp_o3", ext_imm, 32'h3);
      cyc();
      #1 chk("bp_drained", 32'(out_valid), 32'd0);
      cyc();

      // Streaming: 16 back-to-back inputs
      lows = 0; got = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         imm  = 16'($urandom);
         mode = 2'($urandom_range(0, 3));
         #1;
         if (!in_ready) lows++;
         if (out_valid) got++;
         cyc();
      end
      in_valid = 1'b0;
      #1;
      if (out_valid) got++;
      cyc();
      chk("stream_results", 32'(got),  32'd16);
      chk("stream_rdy_low", 32'(lows), 32'd0);

      // Mid-operation asynchronous reset with the buffer full
      out_ready = 1'b0; in_valid = 1'b1;
      imm = 16'hABCD; mode = 2'd1; cyc();
      imm = 16'h5555; mode = 2'd0; cyc();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_ext_imm",   ext_imm,        32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd0);
      q.delete(); rdy = 1'b0; stall_prev = 1'b0;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      cyc();
      #1;
      chk("arst_rdy_rise", 32'(in_ready),  32'd1);
      chk("arst_no_stale", 32'(out_valid), 32'd0);
      cyc();

      // Random handshake soak
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         imm       = 16'($urandom);
         mode      = 2'($urandom_range(0, 3));
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
